// File: rtl/dcache_miss_ctrl.sv
// D-cache miss sequencer: optional dirty-victim write-back, then line refill, over AXI4.
// Ports: clk/reset_n; miss_req/miss_addr/victim_* from MEM stage; wb_idx/wb_data victim read;
//        fill_we/fill_idx/fill_data refill write; done/stall/err status; m_axi_* AXI4 master.
module dcache_miss_ctrl #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  miss_req,
    input  logic [ADDR_W-1:0]     miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_W-1:0]     victim_addr,
    output logic [$clog2(BEATS)-1:0] wb_idx,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  fill_we,
    output logic [$clog2(BEATS)-1:0] fill_idx,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  done,
    output logic                  stall,
    output logic                  err,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int CW  = $clog2(BEATS);
    localparam int OFF = $clog2(BEATS * DATA_W / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DN
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [ADDR_W-OFF-1:0] mline_q;
    logic [ADDR_W-OFF-1:0] vline_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  done_q;
    logic                  err_q;

    // Byte offset within the line is irrelevant: whole lines move.
    logic unused_offs;
    assign unused_offs = ^{miss_addr[OFF-1:0], victim_addr[OFF-1:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mline_q   <= '0;
            vline_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (miss_req) begin
                        mline_q <= miss_addr[ADDR_W-1:OFF];
                        vline_q <= victim_addr[ADDR_W-1:OFF];
                        cnt_q   <= '0;
                        if (victim_dirty) begin
                            awvalid_q <= 1'b1;
                            state_q   <= WB_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_AR;
                        end
                    end
                end
                WB_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= WB_W;
                    end
                end
                WB_W: begin
                    if (m_axi_wready) begin
                        // Wraps to 0 on the last beat, ready for the refill.
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= WB_B;
                        end
                    end
                end
                WB_B: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) err_q <= 1'b1;
                        bready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= RD_AR;
                    end
                end
                RD_AR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_R;
                    end
                end
                RD_R: begin
                    if (m_axi_rvalid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if ((m_axi_rresp != 2'b00) ||
                            (m_axi_rlast != (cnt_q == LAST)))
                            err_q <= 1'b1;
                        // Termination counts beats; RLAST is only checked.
                        if (cnt_q == LAST) begin
                            rready_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DN;
                        end
                    end
                end
                DN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_idx    = cnt_q;
    assign fill_we   = rready_q & m_axi_rvalid;
    assign fill_idx  = cnt_q;
    assign fill_data = m_axi_rdata;
    assign done      = done_q;
    assign stall     = miss_req & ~done_q;
    assign err       = err_q;

    assign m_axi_awaddr  = {vline_q, {OFF{1'b0}}};
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'd3;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wb_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wvalid_q & (cnt_q == LAST);
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = {mline_q, {OFF{1'b0}}};
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: AXI slave + cache-side stimulus with a
// phase-level reference model of one miss (write-back, refill, done).
module tb_dcache_miss_ctrl;
    localparam int NB = 8;
    localparam logic [63:0] LMASK = ~64'h3F;

    logic        clk, reset_n, miss_req, victim_dirty;
    logic [63:0] miss_addr, victim_addr, wb_data, fill_data, wb_base;
    logic [2:0]  wb_idx, fill_idx;
    logic        fill_we, done, stall, err;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic        bvalid, bready, arvalid, arready;
    logic        rlast, rvalid, rready;

    dcache_miss_ctrl dut (
        .clk(clk), .reset_n(reset_n), .miss_req(miss_req),
        .miss_addr(miss_addr), .victim_dirty(victim_dirty),
        .victim_addr(victim_addr), .wb_idx(wb_idx), .wb_data(wb_data),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .done(done), .stall(stall), .err(err),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Victim line storage: word i of the line holds base + i*0x11.
    assign wb_data = wb_base + {61'd0, wb_idx} * 64'h11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0, cyc = 0;
    int aw_dly, w_dly, ar_dly, aw_wait, w_wait, ar_wait;
    int r_sent, rerr_beat, w_n, fill_n, done_n, done_cyc;
    bit active, dirty_m, aw_done, b_done, ar_done, b_pend;
    bit r_taken, r_tog, r_half, exp_err;
    logic [63:0] maddr_m, vaddr_m, wbase;
    logic [63:0] rq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        active = 0; aw_done = 0; b_done = 0; ar_done = 0; b_pend = 0;
        w_n = 0; fill_n = 0; done_n = 0; done_cyc = -1;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        r_sent = 0; r_taken = 0; r_tog = 0;
        rq.delete();
    endtask

    // Runs at the falling edge: compare every output against the phase model.
    task automatic check_cycle();
        bit e_aw, e_w, e_b, e_ar, e_r, e_dn;
        logic [63:0] exp_fd;
        e_aw = active && cyc >= 1 && dirty_m && !aw_done;
        e_w  = aw_done && w_n < NB;
        e_b  = (w_n == NB) && !b_done;
        e_ar = active && cyc >= 1 && (!dirty_m || b_done) && !ar_done;
        e_r  = ar_done && fill_n < NB;
        e_dn = (fill_n == NB) && (done_n == 0);
        chk("done", 64'(done), 64'(e_dn));
        chk("stall", 64'(stall), 64'(miss_req & ~e_dn));
        chk("err", 64'(err), 64'(exp_err));
        chk("awvalid", 64'(awvalid), 64'(e_aw));
        chk("wvalid", 64'(wvalid), 64'(e_w));
        chk("bready", 64'(bready), 64'(e_b));
        chk("arvalid", 64'(arvalid), 64'(e_ar));
        chk("rready", 64'(rready), 64'(e_r));
        chk("fill_we", 64'(fill_we), 64'(rvalid & e_r));
        if (e_aw) begin
            chk("awaddr", awaddr, vaddr_m & LMASK);
            chk("awlen", 64'(awlen), 64'd7);
            chk("awsize", 64'(awsize), 64'd3);
            chk("awburst", 64'(awburst), 64'd1);
            if (awready) begin aw_done = 1; aw_wait = 0; end
            else aw_wait++;
        end
        if (e_w) begin
            chk("wdata", wdata, wbase + 64'(w_n) * 64'h11);
            chk("wlast", 64'(wlast), 64'(w_n == NB - 1));
            chk("wstrb", 64'(wstrb), 64'hFF);
            if (wready) begin
                w_n++; w_wait = 0;
                if (w_n == NB) b_pend = 1;
            end else w_wait++;
        end
        if (e_b && bvalid) begin
            b_done = 1; b_pend = 0;
            if (bresp != 2'b00) exp_err = 1;
        end
        if (e_ar) begin
            chk("araddr", araddr, maddr_m & LMASK);
            chk("arlen", 64'(arlen), 64'd7);
            chk("arsize", 64'(arsize), 64'd3);
            chk("arburst", 64'(arburst), 64'd1);
            if (arready) begin ar_done = 1; ar_wait = 0; end
            else ar_wait++;
        end
        if (e_r && rvalid) begin
            exp_fd = (fill_n < rq.size()) ? rq[fill_n] : 64'hx;
            chk("fill_idx", 64'(fill_idx), 64'(fill_n));
            chk("fill_data", fill_data, exp_fd);
            if (rresp != 2'b00) exp_err = 1;
            fill_n++; r_taken = 1;
        end
        if (e_dn) begin
            done_n++; done_cyc = cyc; active = 0;
        end
    endtask

    task automatic drive_slave();
        awready = (aw_wait >= aw_dly);
        wready  = (w_wait >= w_dly);
        arready = (ar_wait >= ar_dly);
        bvalid  = b_pend;
        bresp   = 2'b00;
        if (rvalid && !r_taken) begin
            rvalid = 1'b1;
        end else if (ar_done && r_sent < NB) begin
            r_tog = !r_tog;
            if (!r_half || r_tog) begin
                rdata = {$urandom, $urandom};
                rq.push_back(rdata);
                rresp = (r_sent == rerr_beat) ? 2'd2 : 2'd0;
                rlast = (r_sent == NB - 1);
                rvalid = 1'b1;
                r_sent++;
            end else begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
            end
        end else begin
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        end
        r_taken = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        drive_slave();
        cyc++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; miss_req = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_model();
        exp_err = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_half = 0; rerr_beat = -1;
        awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
        rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
        cyc = 0;
        tick();
    endtask

    task automatic run_miss(input logic [63:0] addr, input bit dirty,
                            input logic [63:0] vaddr, input logic [63:0] base,
                            input bit bp, input int rerr, input int exp_cyc,
                            input int abort_w);
        clear_model();
        active = 1; dirty_m = dirty; maddr_m = addr;
        vaddr_m = vaddr; wbase = base;
        aw_dly = bp ? 3 : 0; w_dly = bp ? 3 : 0; ar_dly = bp ? 3 : 0;
        r_half = bp; rerr_beat = rerr;
        wb_base = base; miss_req = 1'b1; miss_addr = addr;
        victim_addr = vaddr; victim_dirty = dirty;
        cyc = 0;
        for (int k = 0; k < 400 && active; k++) begin
            tick();
            if (cyc == 1) begin
                // Captured at the first edge; later values must not matter.
                miss_addr = {$urandom, $urandom};
                victim_addr = {$urandom, $urandom};
                victim_dirty = 1'($urandom);
            end
            if (abort_w > 0 && w_n == abort_w) begin
                apply_reset();
                return;
            end
        end
        miss_req = 1'b0;
        chk("timeout", 64'(active), 64'd0);
        chk("fill_count", 64'(fill_n), 64'(NB));
        chk("wbeat_count", 64'(w_n), dirty ? 64'(NB) : 64'd0);
        chk("done_count", 64'(done_n), 64'd1);
        if (exp_cyc >= 0) chk("done_cycle", 64'(done_cyc), 64'(exp_cyc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n = 1'b0; miss_req = 1'b0; victim_dirty = 1'b0;
        miss_addr = '0; victim_addr = '0; wb_base = '0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
        rvalid = 0; rlast = 0; rresp = 0; rdata = 0;
        clear_model(); exp_err = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_half = 0; rerr_beat = -1;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();
        idle(2);

        // Clean miss, zero-wait slave.
        run_miss(64'h1000_0048, 0, 64'h5555_0000, 64'h0, 0, -1, 10, 0);
        idle(2);
        // Dirty miss with write-back.
        run_miss(64'h3000_1234, 1, 64'h2000_0000, 64'h0, 0, -1, 20, 0);
        idle(2);
        // Backpressure on every channel.
        run_miss({$urandom, $urandom}, 1, {$urandom, $urandom},
                 {$urandom, $urandom}, 1, -1, -1, 0);
        idle(1);
        // Error response on beat 3, then a normal miss with err still set.
        run_miss({$urandom, $urandom}, 0, {$urandom, $urandom},
                 64'h0, 0, 3, 10, 0);
        idle(1);
        run_miss({$urandom, $urandom}, 1, {$urandom, $urandom},
                 {$urandom, $urandom}, 0, -1, 20, 0);
        idle(1);
        // Reset in the middle of the write burst, then a fresh miss.
        run_miss({$urandom, $urandom}, 1, {$urandom, $urandom},
                 64'h100, 0, -1, -1, 4);
        idle(1);
        run_miss({$urandom, $urandom}, 1, {$urandom, $urandom},
                 {$urandom, $urandom}, 0, -1, 20, 0);
        // Back-to-back misses with no idle gap.
        run_miss(64'h4000_0010, 0, 64'h0, 64'h0, 0, -1, 10, 0);
        run_miss(64'h4000_0090, 0, 64'h0, 64'h0, 0, -1, 10, 0);
        run_miss(64'h4000_0100, 1, 64'h6000_0040, 64'h77, 0, -1, 20, 0);
        idle(2);
        // Random mix.
        for (int i = 0; i < 6; i++) begin
            bit d, b;
            d = 1'($urandom);
            b = 1'($urandom);
            run_miss({$urandom, $urandom}, d, {$urandom, $urandom},
                     {$urandom, $urandom}, b, -1,
                     b ? -1 : (d ? 20 : 10), 0);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
